// File: rtl/bullet_sched.sv
// rtl/bullet_sched.sv - player bullet fire scheduler: period pacing, round-robin slot pick, double-shot timer
module bullet_sched #(
    parameter int unsigned     BULLET_NUM      = 8,
    parameter int unsigned     IDX_W           = 3,
    parameter int unsigned     FIRE_PERIOD     = 50_000_000,
    parameter longint unsigned DOUBLE_DURATION = 64'd2_500_000_000,
    parameter int unsigned     CNT_W           = 32
) (
    input  logic                  clk_run,
    input  logic                  rst,
    input  logic                  game_run_i,
    input  logic                  powerup_i,
    input  logic [BULLET_NUM-1:0] slot_busy_i,
    output logic                  shoot_o,
    output logic [IDX_W-1:0]      shoot_idx_o,
    output logic                  mode_o,
    output logic [7:0]            miss_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;
    localparam logic [1:0] ST_FIRE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIRE_PERIOD - 1);
    localparam logic [CNT_W-1:0] DBL_LOAD = CNT_W'(DOUBLE_DURATION);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BULLET_NUM - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] period_cnt;
    logic [IDX_W-1:0] scan_ptr;
    logic [IDX_W-1:0] scan_steps;
    logic [IDX_W-1:0] last_idx;
    logic [CNT_W-1:0] dbl_timer;
    logic [CNT_W-1:0] dbl_next;

    // Slot successor with wrap from the last slot back to slot 0
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_LAST) ? '0 : i + IDX_W'(1);
    endfunction

    // Fire FSM: pace with the period counter, scan one slot per cycle, pulse shoot for one cycle
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            period_cnt  <= '0;
            scan_ptr    <= '0;
            scan_steps  <= '0;
            last_idx    <= IDX_LAST;
            shoot_o     <= 1'b0;
            shoot_idx_o <= '0;
            miss_cnt_o  <= 8'd0;
        end else begin
            shoot_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (game_run_i) begin
                        state      <= ST_COUNT;
                        period_cnt <= '0;
                    end
                end
                ST_COUNT: begin
                    if (!game_run_i) begin
                        state      <= ST_IDLE;
                        period_cnt <= '0;
                    end else if (period_cnt == CNT_LAST) begin
                        state      <= ST_SCAN;
                        period_cnt <= '0;
                        scan_ptr   <= next_idx(last_idx);
                        scan_steps <= '0;
                    end else begin
                        period_cnt <= period_cnt + CNT_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (!game_run_i) begin
                        state      <= ST_IDLE;
                        period_cnt <= '0;
                    end else if (!slot_busy_i[scan_ptr]) begin
                        state       <= ST_FIRE;
                        shoot_idx_o <= scan_ptr;
                        shoot_o     <= 1'b1;
                    end else if (scan_steps == IDX_LAST) begin
                        // Whole pool busy: drop this attempt and count it
                        if (miss_cnt_o != 8'hFF) begin
                            miss_cnt_o <= miss_cnt_o + 8'd1;
                        end
                        state      <= ST_COUNT;
                        period_cnt <= '0;
                    end else begin
                        scan_ptr   <= next_idx(scan_ptr);
                        scan_steps <= scan_steps + IDX_W'(1);
                    end
                end
                ST_FIRE: begin
                    // A shot in flight completes even if the game pauses this cycle
                    last_idx   <= shoot_idx_o;
                    state      <= ST_COUNT;
                    period_cnt <= '0;
                end
                default: begin
                    state      <= ST_IDLE;
                    period_cnt <= '0;
                end
            endcase
        end
    end

    // Next double-timer value: power-up reload wins, otherwise count down while running
    always_comb begin
        dbl_next = dbl_timer;
        if (powerup_i) begin
            dbl_next = DBL_LOAD;
        end else if (game_run_i && (dbl_timer != '0)) begin
            dbl_next = dbl_timer - CNT_W'(1);
        end
    end

    // Double timer and registered mode flag tracking the timer's new value
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            dbl_timer <= '0;
            mode_o    <= 1'b0;
        end else begin
            dbl_timer <= dbl_next;
            mode_o    <= (dbl_next != '0);
        end
    end

endmodule

// File: tb/tb_bullet_sched.sv
// tb/tb_bullet_sched.sv - randomized and directed self-checking bench for bullet_sched
module tb_bullet_sched;

    localparam int BN = 4;
    localparam int FP = 4;
    localparam int DD = 20;

    logic       clk_run = 1'b0;
    logic       rst;
    logic       game_run_i;
    logic       powerup_i;
    logic [3:0] slot_busy_i;
    logic       shoot_o;
    logic [1:0] shoot_idx_o;
    logic       mode_o;
    logic [7:0] miss_cnt_o;

    bullet_sched #(
        .BULLET_NUM(BN),
        .IDX_W(2),
        .FIRE_PERIOD(FP),
        .DOUBLE_DURATION(DD),
        .CNT_W(32)
    ) dut (
        .clk_run(clk_run),
        .rst(rst),
        .game_run_i(game_run_i),
        .powerup_i(powerup_i),
        .slot_busy_i(slot_busy_i),
        .shoot_o(shoot_o),
        .shoot_idx_o(shoot_idx_o),
        .mode_o(mode_o),
        .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_run = ~clk_run;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: remaining wait, queue of slots still to try, timer as plain integer
    logic       e_shoot;
    logic [1:0] e_idx;
    logic       e_mode;
    logic [7:0] e_miss;
    int         m_timer;
    int         m_last;
    int         m_elapsed;
    bit         m_idle;
    bit         m_firing;
    int         m_cand[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        e_shoot   = 1'b0;
        e_idx     = 2'd0;
        e_mode    = 1'b0;
        e_miss    = 8'd0;
        m_timer   = 0;
        m_last    = BN - 1;
        m_elapsed = 0;
        m_idle    = 1'b1;
        m_firing  = 1'b0;
        m_cand.delete();
    endtask

    task automatic model_step(input bit gr, input bit pu, input logic [3:0] busy);
        e_shoot = 1'b0;
        if (pu) m_timer = DD;
        else if (gr && m_timer > 0) m_timer--;
        e_mode = (m_timer > 0);
        if (m_firing) begin
            m_last    = int'(e_idx);
            m_firing  = 1'b0;
            m_elapsed = 0;
        end else if (m_idle) begin
            if (gr) begin
                m_idle    = 1'b0;
                m_elapsed = 0;
            end
        end else if (m_cand.size() > 0) begin
            if (!gr) begin
                m_idle = 1'b1;
                m_cand.delete();
            end else begin
                int h;
                h = m_cand.pop_front();
                if (!busy[h]) begin
                    e_idx    = 2'(h);
                    e_shoot  = 1'b1;
                    m_firing = 1'b1;
                    m_cand.delete();
                end else if (m_cand.size() == 0) begin
                    if (e_miss != 8'd255) e_miss++;
                    m_elapsed = 0;
                end
            end
        end else begin
            if (!gr) begin
                m_idle = 1'b1;
            end else if (m_elapsed == FP - 1) begin
                for (int j = 1; j <= BN; j++) m_cand.push_back((m_last + j) % BN);
            end else begin
                m_elapsed++;
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge
    task automatic cycle(input bit gr, input bit pu, input logic [3:0] busy);
        game_run_i  = gr;
        powerup_i   = pu;
        slot_busy_i = busy;
        @(posedge clk_run);
        model_step(gr, pu, busy);
        cyc++;
        @(negedge clk_run);
        chk("shoot", 32'(shoot_o), 32'(e_shoot));
        chk("shoot_idx", 32'(shoot_idx_o), 32'(e_idx));
        chk("mode", 32'(mode_o), 32'(e_mode));
        chk("miss_cnt", 32'(miss_cnt_o), 32'(e_miss));
    endtask

    int sh_t[$];
    int sh_i[$];
    int n;
    int hi;
    int t_ref;
    int ex_idx;

    initial begin
        rst         = 1'b1;
        game_run_i  = 1'b0;
        powerup_i   = 1'b0;
        slot_busy_i = 4'd0;
        model_reset();
        repeat (2) @(negedge clk_run);
        chk("rst_shoot", 32'(shoot_o), 32'd0);
        chk("rst_idx", 32'(shoot_idx_o), 32'd0);
        chk("rst_mode", 32'(mode_o), 32'd0);
        chk("rst_miss", 32'(miss_cnt_o), 32'd0);
        rst = 1'b0;

        // Free pool: shots every 6 cycles walking 0,1,2,3,0
        n = 0;
        while (sh_t.size() < 5 && n < 80) begin
            cycle(1, 0, 4'b0000);
            n++;
            if (shoot_o) begin
                sh_t.push_back(cyc);
                sh_i.push_back(int'(shoot_idx_o));
            end
        end
        chk("rr_count", 32'(sh_t.size()), 32'd5);
        if (sh_t.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("rr_idx", 32'(sh_i[i]), 32'(i % BN));
            for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(sh_t[i] - sh_t[i-1]), 32'd6);
        end

        // Shot on slot 1, then slot 2 busy: next shot on slot 3 after 7 cycles
        n = 0;
        do begin
            cycle(1, 0, 4'b0000);
            n++;
        end while (!(shoot_o && shoot_idx_o == 2'd1) && n < 40);
        chk("wait_idx1", 32'(shoot_idx_o), 32'd1);
        t_ref = cyc;
        n = 0;
        do begin
            cycle(1, 0, 4'b0100);
            n++;
        end while (!shoot_o && n < 40);
        chk("skip_idx", 32'(shoot_idx_o), 32'd3);
        chk("skip_spacing", 32'(cyc - t_ref), 32'd7);

        // Full pool: one miss per 8-cycle attempt, saturating at 255
        repeat (9) cycle(1, 0, 4'b1111);
        chk("miss_first", 32'(miss_cnt_o), 32'd1);
        repeat (8) cycle(1, 0, 4'b1111);
        chk("miss_second", 32'(miss_cnt_o), 32'd2);
        repeat (2400) cycle(1, 0, 4'b1111);
        chk("miss_sat", 32'(miss_cnt_o), 32'd255);

        // Power-up: 20 running cycles of double mode
        cycle(1, 1, 4'b1111);
        hi = int'(mode_o);
        n = 0;
        while (mode_o && n < 100) begin
            cycle(1, 0, 4'b1111);
            hi += int'(mode_o);
            n++;
        end
        chk("dbl_len", 32'(hi), 32'd20);

        // Power-up with a 10-cycle pause mid-window: 30 cycles of double mode
        cycle(1, 1, 4'b1111);
        hi = int'(mode_o);
        repeat (4) begin cycle(1, 0, 4'b1111); hi += int'(mode_o); end
        repeat (10) begin cycle(0, 0, 4'b1111); hi += int'(mode_o); end
        n = 0;
        while (mode_o && n < 100) begin
            cycle(1, 0, 4'b1111);
            hi += int'(mode_o);
            n++;
        end
        chk("dbl_pause_len", 32'(hi), 32'd30);

        // Re-trigger at remaining time 5 reloads to 20: 1+15+1+19 cycles
        cycle(1, 1, 4'b1111);
        hi = int'(mode_o);
        repeat (15) begin cycle(1, 0, 4'b1111); hi += int'(mode_o); end
        cycle(1, 1, 4'b1111);
        hi += int'(mode_o);
        n = 0;
        while (mode_o && n < 100) begin
            cycle(1, 0, 4'b1111);
            hi += int'(mode_o);
            n++;
        end
        chk("dbl_reload_len", 32'(hi), 32'd36);

        // Pause in a SCAN cycle: no shot; resume scans from last+1 after 4 COUNT cycles
        n = 0;
        while (m_cand.size() == 0 && n < 40) begin
            cycle(1, 0, 4'b0000);
            n++;
        end
        chk("reach_scan", 32'(m_cand.size() > 0), 32'd1);
        hi = 0;
        repeat (3) begin cycle(0, 0, 4'b0000); hi += int'(shoot_o); end
        chk("pause_noshot", 32'(hi), 32'd0);
        ex_idx = (m_last + 1) % BN;
        n = 0;
        do begin
            cycle(1, 0, 4'b0000);
            n++;
        end while (!shoot_o && n < 20);
        chk("resume_latency", 32'(n), 32'd6);
        chk("resume_idx", 32'(shoot_idx_o), 32'(ex_idx));

        // Reset during a FIRE cycle with double mode and misses active
        cycle(1, 1, 4'b0000);
        n = 0;
        while (!shoot_o && n < 20) begin
            cycle(1, 0, 4'b0000);
            n++;
        end
        chk("fire_before_rst", 32'(shoot_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_shoot", 32'(shoot_o), 32'd0);
        chk("arst_mode", 32'(mode_o), 32'd0);
        chk("arst_miss", 32'(miss_cnt_o), 32'd0);
        chk("arst_idx", 32'(shoot_idx_o), 32'd0);
        model_reset();
        @(negedge clk_run);
        rst = 1'b0;
        n = 0;
        do begin
            cycle(1, 0, 4'b0000);
            n++;
        end while (!shoot_o && n < 20);
        chk("post_rst_idx", 32'(shoot_idx_o), 32'd0);
        chk("post_rst_shot", 32'(shoot_o), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 19) != 0,
                  $urandom_range(0, 49) == 0,
                  4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
